cam_line_capture: RTL and testbench

Parametrised camera capture front-end: samples an 8-bit-style parallel camera bus (pixel clock, href, vsync, data) in the system clock domain. It packs consecutive bytes into pixel words, keeps only a rectangular window of lines and columns with a programmable line stride, and emits single-cycle write strobes with pixel and line addresses into the line buffer. It sits between the camera pins and the line-buffer/detector pipeline.

---
 rtl/cam_pkg.sv | 20 ++
 rtl/cam_sync_edge.sv | 49 ++++
 rtl/cam_line_capture.sv | 231 +++++++++++++++++++++++
 tb/tb_cam_line_capture.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : cam_pkg
//  Description: Shared state encodings and synchroniser depth for the
//               camera capture blocks.
//  Revision   : 1.0 - initial release
// ============================================================================
package cam_pkg;

    localparam int c_SYNC_DEPTH = 2;

    typedef logic [1:0] cam_state_t;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SKIP = 2'd1;
    localparam logic [1:0] c_ST_HOT  = 2'd2;
    localparam logic [1:0] c_ST_OMIT = 2'd3;

endpackage
`default_nettype wire

// File: rtl/cam_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module     : cam_sync_edge
//  Description: Single-bit synchroniser with a trailing flop for registered
//               rise/fall detection; level output is aligned with the edges.
//  Revision   : 1.0 - initial release
// ============================================================================
module cam_sync_edge
    import cam_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [c_SYNC_DEPTH:0] sync_q;
    logic [c_SYNC_DEPTH:0] sync_d;
    logic                  rise_q;
    logic                  rise_d;
    logic                  fall_q;
    logic                  fall_d;

    always_comb begin
        sync_d = {sync_q[c_SYNC_DEPTH-1:0], i_async};
        rise_d = sync_q[c_SYNC_DEPTH-1] & ~sync_q[c_SYNC_DEPTH];
        fall_d = ~sync_q[c_SYNC_DEPTH-1] & sync_q[c_SYNC_DEPTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign o_level = sync_q[c_SYNC_DEPTH];
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;

endmodule
`default_nettype wire

// File: rtl/cam_line_capture.sv
`default_nettype none
// ============================================================================
//  Module     : cam_line_capture
//  Description: Camera bus capture front-end: synchronises the parallel bus,
//               packs bytes into pixels and writes a strided line window.
//  Revision   : 1.0 - initial release
// ============================================================================
module cam_line_capture
    import cam_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int BYTES_PER_PIX = 2,
    parameter int H_ADDR_W      = 9,
    parameter int V_ADDR_W      = 8,
    parameter int TOP_SKIP      = 244,
    parameter int LINE_STRIDE   = 12,
    parameter int X_START       = 0,
    parameter int X_COUNT       = 320
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic                            cam_pclk,
    input  logic                            cam_href,
    input  logic                            cam_vsync,
    input  logic [DATA_W-1:0]               cam_data,
    output logic                            wr_en,
    output logic [DATA_W*BYTES_PER_PIX-1:0] wr_data,
    output logic [H_ADDR_W-1:0]             wr_x,
    output logic [V_ADDR_W-1:0]             wr_line,
    output logic                            line_done,
    output logic                            frame_start,
    output logic                            short_line
);

    localparam int WORD_W  = DATA_W * BYTES_PER_PIX;
    localparam int PIX_W   = H_ADDR_W + 1;
    localparam int PH_W    = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
    localparam int CNT_MAX = (TOP_SKIP > LINE_STRIDE) ? TOP_SKIP : LINE_STRIDE;
    localparam int CNT_W   = $clog2(CNT_MAX + 2);

    localparam logic [PIX_W-1:0] c_X_LO     = PIX_W'(X_START);
    localparam logic [PIX_W-1:0] c_X_HI     = PIX_W'(X_START + X_COUNT);
    localparam logic [PIX_W-1:0] c_X_CNT    = PIX_W'(X_COUNT);
    localparam logic [PH_W-1:0]  c_LAST_PH  = PH_W'(BYTES_PER_PIX - 1);
    localparam logic [CNT_W-1:0] c_SKIP_N   = CNT_W'(TOP_SKIP);
    localparam logic [CNT_W-1:0] c_OMIT_N   = CNT_W'(LINE_STRIDE - 1);

    logic pclk_rise, pclk_lvl_unused, pclk_fall_unused;
    logic href_lvl, href_rise, href_fall;
    logic vsync_rise, vsync_fall, vsync_lvl_unused;

    cam_sync_edge u_sync_pclk (
        .clk(clk), .rst(rst), .i_async(cam_pclk),
        .o_level(pclk_lvl_unused), .o_rise(pclk_rise), .o_fall(pclk_fall_unused)
    );
    cam_sync_edge u_sync_href (
        .clk(clk), .rst(rst), .i_async(cam_href),
        .o_level(href_lvl), .o_rise(href_rise), .o_fall(href_fall)
    );
    cam_sync_edge u_sync_vsync (
        .clk(clk), .rst(rst), .i_async(cam_vsync),
        .o_level(vsync_lvl_unused), .o_rise(vsync_rise), .o_fall(vsync_fall)
    );

    logic [c_SYNC_DEPTH:0][DATA_W-1:0] data_pipe_q, data_pipe_d;
    logic [DATA_W-1:0]                 cam_byte;

    cam_state_t           state_q, state_d;
    logic [CNT_W-1:0]     line_cnt_q, line_cnt_d;
    logic [V_ADDR_W-1:0]  wr_line_q, wr_line_d;
    logic [PH_W-1:0]      phase_q, phase_d, ph_v;
    logic [PIX_W-1:0]     pix_q, pix_d, pix_v;
    logic [PIX_W-1:0]     wcnt_q, wcnt_d, wcnt_v;
    logic [WORD_W-1:0]    word_q, word_d;
    logic                 active_q, active_d;
    logic                 wr_en_q, wr_en_d;
    logic [WORD_W-1:0]    wr_data_q, wr_data_d;
    logic [H_ADDR_W-1:0]  wr_x_q, wr_x_d;
    logic                 line_done_q, line_done_d;
    logic                 frame_start_q, frame_start_d;
    logic                 short_line_q, short_line_d;

    // Data is delayed by the same depth as the control edges it is paired with.
    assign data_pipe_d = {data_pipe_q[c_SYNC_DEPTH-1:0], cam_data};
    assign cam_byte    = data_pipe_q[c_SYNC_DEPTH];

    always_comb begin
        state_d       = state_q;
        line_cnt_d    = line_cnt_q;
        wr_line_d     = wr_line_q;
        word_d        = word_q;
        active_d      = active_q;
        wr_en_d       = 1'b0;
        wr_data_d     = wr_data_q;
        wr_x_d        = wr_x_q;
        line_done_d   = 1'b0;
        frame_start_d = 1'b0;
        short_line_d  = 1'b0;
        ph_v          = phase_q;
        pix_v         = pix_q;
        wcnt_v        = wcnt_q;

        if (vsync_rise) begin
            state_d  = c_ST_IDLE;
            active_d = 1'b0;
        end else begin
            case (state_q)
                c_ST_IDLE: begin
                    if (vsync_fall && enable) begin
                        frame_start_d = 1'b1;
                        line_cnt_d    = '0;
                        wr_line_d     = '0;
                        active_d      = 1'b0;
                        state_d       = (TOP_SKIP == 0) ? c_ST_HOT : c_ST_SKIP;
                    end
                end
                c_ST_SKIP: begin
                    if (href_fall) begin
                        if (line_cnt_q + CNT_W'(1) == c_SKIP_N) begin
                            state_d    = c_ST_HOT;
                            line_cnt_d = '0;
                        end else begin
                            line_cnt_d = line_cnt_q + CNT_W'(1);
                        end
                    end
                end
                c_ST_HOT: begin
                    if (href_rise) begin
                        ph_v     = '0;
                        pix_v    = '0;
                        wcnt_v   = '0;
                        active_d = 1'b1;
                    end
                    // Only lines whose start was seen in HOT are packed.
                    if (pclk_rise && href_lvl && (active_q || href_rise)) begin
                        word_d = (word_q << DATA_W) | WORD_W'(cam_byte);
                        if (ph_v == c_LAST_PH) begin
                            ph_v = '0;
                            if (pix_v >= c_X_LO && pix_v < c_X_HI) begin
                                wr_en_d   = 1'b1;
                                wr_data_d = word_d;
                                wr_x_d    = H_ADDR_W'(pix_v - c_X_LO);
                                wcnt_v    = wcnt_v + PIX_W'(1);
                            end
                            if (pix_v != '1) begin
                                pix_v = pix_v + PIX_W'(1);
                            end
                        end else begin
                            ph_v = ph_v + PH_W'(1);
                        end
                    end
                    if (href_fall) begin
                        line_done_d  = 1'b1;
                        short_line_d = (wcnt_v < c_X_CNT);
                        active_d     = 1'b0;
                        if (wr_line_q == '1) begin
                            state_d = c_ST_IDLE;
                        end else begin
                            wr_line_d = wr_line_q + V_ADDR_W'(1);
                            if (LINE_STRIDE > 1) begin
                                state_d    = c_ST_OMIT;
                                line_cnt_d = '0;
                            end
                        end
                    end
                end
                default: begin
                    if (href_fall) begin
                        if (line_cnt_q + CNT_W'(1) == c_OMIT_N) begin
                            state_d    = c_ST_HOT;
                            line_cnt_d = '0;
                        end else begin
                            line_cnt_d = line_cnt_q + CNT_W'(1);
                        end
                    end
                end
            endcase
        end

        phase_d = ph_v;
        pix_d   = pix_v;
        wcnt_d  = wcnt_v;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_pipe_q   <= '0;
            state_q       <= c_ST_IDLE;
            line_cnt_q    <= '0;
            wr_line_q     <= '0;
            phase_q       <= '0;
            pix_q         <= '0;
            wcnt_q        <= '0;
            word_q        <= '0;
            active_q      <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_data_q     <= '0;
            wr_x_q        <= '0;
            line_done_q   <= 1'b0;
            frame_start_q <= 1'b0;
            short_line_q  <= 1'b0;
        end else begin
            data_pipe_q   <= data_pipe_d;
            state_q       <= state_d;
            line_cnt_q    <= line_cnt_d;
            wr_line_q     <= wr_line_d;
            phase_q       <= phase_d;
            pix_q         <= pix_d;
            wcnt_q        <= wcnt_d;
            word_q        <= word_d;
            active_q      <= active_d;
            wr_en_q       <= wr_en_d;
            wr_data_q     <= wr_data_d;
            wr_x_q        <= wr_x_d;
            line_done_q   <= line_done_d;
            frame_start_q <= frame_start_d;
            short_line_q  <= short_line_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_data     = wr_data_q;
    assign wr_x        = wr_x_q;
    assign wr_line     = wr_line_q;
    assign line_done   = line_done_q;
    assign frame_start = frame_start_q;
    assign short_line  = short_line_q;

endmodule
`default_nettype wire

// File: tb/tb_cam_line_capture.sv
`default_nettype none
// ============================================================================
//  Module     : tb_cam_line_capture
//  Description: Directed self-checking bench for cam_line_capture (strided
//               window instance plus an every-line instance for latency).
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_cam_line_capture;

    typedef struct packed {
        logic [7:0]  line;
        logic [8:0]  x;
        logic [15:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance 1: TOP_SKIP=2, LINE_STRIDE=3
    logic        enable = 1'b0, cam_pclk = 1'b0, cam_href = 1'b0, cam_vsync = 1'b0;
    logic [7:0]  cam_data = 8'h00;
    logic        wr_en, line_done, frame_start, short_line;
    logic [15:0] wr_data;
    logic [8:0]  wr_x;
    logic [7:0]  wr_line;

    // Instance 2: TOP_SKIP=0, LINE_STRIDE=1
    logic        enable2 = 1'b1, pclk2 = 1'b0, href2 = 1'b0, vsync2 = 1'b0;
    logic [7:0]  data2 = 8'h00;
    logic        wr_en2, line_done2, frame_start2, short_line2;
    logic [15:0] wr_data2;
    logic [8:0]  wr_x2;
    logic [7:0]  wr_line2;

    cam_line_capture #(
        .DATA_W(8), .BYTES_PER_PIX(2), .H_ADDR_W(9), .V_ADDR_W(8),
        .TOP_SKIP(2), .LINE_STRIDE(3), .X_START(1), .X_COUNT(4)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .cam_pclk(cam_pclk), .cam_href(cam_href), .cam_vsync(cam_vsync), .cam_data(cam_data),
        .wr_en(wr_en), .wr_data(wr_data), .wr_x(wr_x), .wr_line(wr_line),
        .line_done(line_done), .frame_start(frame_start), .short_line(short_line)
    );

    cam_line_capture #(
        .DATA_W(8), .BYTES_PER_PIX(2), .H_ADDR_W(9), .V_ADDR_W(8),
        .TOP_SKIP(0), .LINE_STRIDE(1), .X_START(1), .X_COUNT(4)
    ) dut2 (
        .clk(clk), .rst(rst), .enable(enable2),
        .cam_pclk(pclk2), .cam_href(href2), .cam_vsync(vsync2), .cam_data(data2),
        .wr_en(wr_en2), .wr_data(wr_data2), .wr_x(wr_x2), .wr_line(wr_line2),
        .line_done(line_done2), .frame_start(frame_start2), .short_line(short_line2)
    );

    int checks = 0;
    int errors = 0;

    wr_t wq[$];
    wr_t wq2[$];
    int  n_done = 0, n_fs = 0, n_short = 0, n_sd = 0;
    int  n_done2 = 0, n_fs2 = 0;

    always @(negedge clk) begin
        if (wr_en) wq.push_back({wr_line, wr_x, wr_data});
        if (line_done) n_done++;
        if (frame_start) n_fs++;
        if (short_line) n_short++;
        if (short_line && line_done) n_sd++;
        if (wr_en2) wq2.push_back({wr_line2, wr_x2, wr_data2});
        if (line_done2) n_done2++;
        if (frame_start2) n_fs2++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Entry i of a capture run: wr_line i/4, wr_x i%4, camera line first+step*(i/4).
    task automatic check_writes(input string tag, input bit use2, input int base,
                                input int n, input int first, input int step);
        wr_t e;
        int  k, x, l;
        int  sz;
        sz = use2 ? wq2.size() : wq.size();
        chk({tag, "_count"}, 32'(sz - base), 32'(n));
        if (sz >= base + n) begin
            for (int i = 0; i < n; i++) begin
                e = use2 ? wq2[base+i] : wq[base+i];
                k = i / 4;
                x = i % 4;
                l = first + step * k;
                chk({tag, "_line"}, 32'(e.line), 32'(k));
                chk({tag, "_x"},    32'(e.x),    32'(x));
                chk({tag, "_data"}, 32'(e.data),
                    32'({8'(l*16 + 2 + 2*x), 8'(l*16 + 3 + 2*x)}));
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        cam_pclk = 1'b0;
        cam_data = b;
        #40;
        cam_pclk = 1'b1;
        #40;
    endtask

    task automatic send_line(input int l, input int n);
        cam_href = 1'b1;
        #80;
        for (int c = 0; c < n; c++) send_byte(8'(l*16 + c));
        #40;
        cam_pclk = 1'b0;
        cam_href = 1'b0;
        #160;
    endtask

    task automatic start_frame(input logic en);
        enable    = en;
        cam_vsync = 1'b1;
        #160;
        cam_vsync = 1'b0;
        #160;
    endtask

    task automatic end_frame();
        cam_vsync = 1'b1;
        #160;
    endtask

    task automatic send_byte2(input logic [7:0] b);
        @(negedge clk);
        pclk2 = 1'b0;
        data2 = b;
        repeat (4) @(negedge clk);
        pclk2 = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int base, fs0, d0, s0, sd0, lat;
        logic [15:0] lat_data;
        logic [8:0]  lat_x;

        // Reset state
        #23;
        chk("rst_flags", {28'd0, wr_en, line_done, frame_start, short_line}, 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_wr_x", 32'(wr_x), 32'd0);
        chk("rst_wr_line", 32'(wr_line), 32'd0);
        chk("rst2_flags", {28'd0, wr_en2, line_done2, frame_start2, short_line2}, 32'd0);
        rst = 1'b0;
        #100;

        // Full frame: captured lines 2,5,8,11
        base = wq.size(); fs0 = n_fs; d0 = n_done; s0 = n_short;
        start_frame(1'b1);
        for (int l = 0; l < 12; l++) send_line(l, 12);
        chk("f1_wr_data_held", 32'(wr_data), 32'h0000B8B9);
        chk("f1_wr_x_held", 32'(wr_x), 32'd3);
        end_frame();
        check_writes("f1", 1'b0, base, 16, 2, 3);
        chk("f1_frame_start", 32'(n_fs - fs0), 32'd1);
        chk("f1_line_done", 32'(n_done - d0), 32'd4);
        chk("f1_short", 32'(n_short - s0), 32'd0);

        // Short HOT line of 7 bytes
        base = wq.size(); d0 = n_done; s0 = n_short; sd0 = n_sd;
        start_frame(1'b1);
        send_line(0, 12);
        send_line(1, 12);
        send_line(2, 7);
        end_frame();
        check_writes("short", 1'b0, base, 2, 2, 3);
        chk("short_line_done", 32'(n_done - d0), 32'd1);
        chk("short_pulse", 32'(n_short - s0), 32'd1);
        chk("short_with_done", 32'(n_sd - sd0), 32'd1);

        // Disabled frame then enabled frame
        base = wq.size(); fs0 = n_fs;
        start_frame(1'b0);
        for (int l = 0; l < 12; l++) send_line(l, 12);
        end_frame();
        chk("dis_writes", 32'(wq.size() - base), 32'd0);
        chk("dis_frame_start", 32'(n_fs - fs0), 32'd0);
        base = wq.size(); fs0 = n_fs;
        start_frame(1'b1);
        for (int l = 0; l < 12; l++) send_line(l, 12);
        end_frame();
        check_writes("reen", 1'b0, base, 16, 2, 3);
        chk("reen_frame_start", 32'(n_fs - fs0), 32'd1);

        // vsync rise in the middle of captured line 5
        base = wq.size(); d0 = n_done;
        start_frame(1'b1);
        for (int l = 0; l < 5; l++) send_line(l, 12);
        cam_href = 1'b1;
        #80;
        for (int c = 0; c < 4; c++) send_byte(8'(5*16 + c));
        #80;
        cam_vsync = 1'b1;
        #160;
        for (int c = 4; c < 12; c++) send_byte(8'(5*16 + c));
        #40;
        cam_pclk = 1'b0;
        cam_href = 1'b0;
        #160;
        chk("abort_count", 32'(wq.size() - base), 32'd5);
        if (wq.size() >= base + 5) begin
            chk("abort_last_line", 32'(wq[base+4].line), 32'd1);
            chk("abort_last_x", 32'(wq[base+4].x), 32'd0);
            chk("abort_last_data", 32'(wq[base+4].data), 32'h00005253);
        end
        chk("abort_line_done", 32'(n_done - d0), 32'd1);
        base = wq.size();
        start_frame(1'b1);
        for (int l = 0; l < 3; l++) send_line(l, 12);
        end_frame();
        check_writes("restart", 1'b0, base, 4, 2, 3);

        // Reset after the first byte of a captured pixel
        start_frame(1'b1);
        send_line(0, 12);
        send_line(1, 12);
        cam_href = 1'b1;
        #80;
        send_byte(8'h20);
        #3;
        rst = 1'b1;
        #2;
        chk("mrst_flags", {28'd0, wr_en, line_done, frame_start, short_line}, 32'd0);
        chk("mrst_wr_data", 32'(wr_data), 32'd0);
        chk("mrst_wr_x", 32'(wr_x), 32'd0);
        chk("mrst_wr_line", 32'(wr_line), 32'd0);
        #50;
        rst = 1'b0;
        base = wq.size();
        for (int c = 1; c < 12; c++) send_byte(8'(2*16 + c));
        #40;
        cam_pclk = 1'b0;
        cam_href = 1'b0;
        #160;
        for (int l = 3; l < 6; l++) send_line(l, 12);
        chk("mrst_no_writes", 32'(wq.size() - base), 32'd0);
        base = wq.size();
        start_frame(1'b1);
        send_line(0, 12);
        send_line(1, 12);
        chk("mrst_skip_writes", 32'(wq.size() - base), 32'd0);
        send_line(2, 12);
        end_frame();
        check_writes("mrst_after", 1'b0, base, 4, 2, 3);

        // Every-line instance: latency of the first windowed pixel
        @(negedge clk);
        vsync2 = 1'b1;
        repeat (16) @(negedge clk);
        vsync2 = 1'b0;
        repeat (16) @(negedge clk);
        href2 = 1'b1;
        repeat (8) @(negedge clk);
        for (int c = 0; c < 3; c++) send_byte2(8'(c));
        @(negedge clk);
        pclk2 = 1'b0;
        data2 = 8'h03;
        repeat (4) @(negedge clk);
        pclk2 = 1'b1;
        lat = -1;
        lat_data = '0;
        lat_x = '0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (wr_en2 && lat < 0) begin
                lat = k;
                lat_data = wr_data2;
                lat_x = wr_x2;
            end
        end
        chk("lat_edges", 32'(lat), 32'd3);
        chk("lat_data", 32'(lat_data), 32'h00000203);
        chk("lat_x", 32'(lat_x), 32'd0);
        for (int c = 4; c < 10; c++) send_byte2(8'(c));
        repeat (4) @(negedge clk);
        pclk2 = 1'b0;
        href2 = 1'b0;
        repeat (16) @(negedge clk);
        href2 = 1'b1;
        repeat (8) @(negedge clk);
        for (int c = 0; c < 10; c++) send_byte2(8'(16 + c));
        repeat (4) @(negedge clk);
        pclk2 = 1'b0;
        href2 = 1'b0;
        repeat (16) @(negedge clk);
        vsync2 = 1'b1;
        repeat (16) @(negedge clk);
        check_writes("every", 1'b1, 0, 8, 0, 1);
        chk("every_frame_start", 32'(n_fs2), 32'd1);
        chk("every_line_done", 32'(n_done2), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
